// File: rtl/frame_source_arbiter_pkg.sv
// Shared frame-sync definitions: arbiter FSM encodings and requester channel indices.
package frame_source_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_ARB       = 3'd0,
        ST_WAIT_IN   = 3'd1,
        ST_READ      = 3'd2,
        ST_GET       = 3'd3,
        ST_CHECK_OUT = 3'd4,
        ST_WRITE     = 3'd5
    } state_t;

    localparam logic CH0_IDX = 1'b0;
    localparam logic CH1_IDX = 1'b1;

    function automatic logic [1:0] ch_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/frame_source_arbiter_rr_grant2.sv
// Two-requester round-robin tie-break: on contention the channel not served last wins.
module rr_grant2
    import frame_source_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    // One-hot grant from the request pair and the last-served channel.
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = ch_onehot(~i_last);
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/frame_source_arbiter.sv
// Moves PAYLOAD_LEN-bit blocks, one bit at a time, from two requester FIFOs into
// one downstream FIFO; ownership is held for a whole block and alternates on contention.
module frame_source_arbiter
    import frame_source_arbiter_pkg::*;
#(
    parameter int PAYLOAD_LEN = 48
)(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CH0_DATA,
    input  logic       CH1_DATA,
    output logic       CH0_RE,
    output logic       CH1_RE,
    input  logic       CH0_EMPTY,
    input  logic       CH1_EMPTY,
    output logic       OUT_DATA,
    output logic       OUT_WE,
    input  logic       OUT_FULL,
    output logic [1:0] GRANT,
    output logic       BUSY
);

    localparam int                CNT_W    = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PAYLOAD_LEN - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_grant;
    logic [1:0]       w_grant_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic             r_bit;
    logic             w_bit_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_arb_grant;
    logic             w_own_empty;
    logic             w_own_data;

    rr_grant2 u_rr_grant2 (
        .i_req   ({~CH1_EMPTY, ~CH0_EMPTY}),
        .i_last  (r_last),
        .o_grant (w_arb_grant)
    );

    // Owner-side views; only consulted while a grant is held.
    assign w_own_empty = r_grant[1] ? CH1_EMPTY : CH0_EMPTY;
    assign w_own_data  = r_grant[1] ? CH1_DATA  : CH0_DATA;

    // State, grant, last-served, captured bit and bit counter registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_ARB;
            r_grant <= 2'b00;
            r_last  <= CH1_IDX;
            r_bit   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_bit   <= w_bit_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_bit_nxt   = r_bit;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_ARB: begin
                if (w_arb_grant != 2'b00) begin
                    w_grant_nxt = w_arb_grant;
                    w_state_nxt = ST_READ;
                end else begin
                    w_state_nxt = ST_ARB;
                end
            end
            ST_WAIT_IN: begin
                if (w_own_empty) begin
                    w_state_nxt = ST_WAIT_IN;
                end else begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                w_state_nxt = ST_GET;
            end
            ST_GET: begin
                w_bit_nxt   = w_own_data;
                w_state_nxt = ST_CHECK_OUT;
            end
            ST_CHECK_OUT: begin
                if (OUT_FULL) begin
                    w_state_nxt = ST_CHECK_OUT;
                end else begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_last_nxt  = r_grant[1] ? CH1_IDX : CH0_IDX;
                    w_grant_nxt = 2'b00;
                    w_state_nxt = ST_ARB;
                end else begin
                    w_cnt_nxt   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    w_state_nxt = ST_WAIT_IN;
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
                w_grant_nxt = 2'b00;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // All outputs decode registered state/grant only, so no input reaches them combinationally.
    assign CH0_RE   = (r_state == ST_READ) & r_grant[0];
    assign CH1_RE   = (r_state == ST_READ) & r_grant[1] & ~r_grant[0];
    assign OUT_WE   = (r_state == ST_WRITE);
    assign OUT_DATA = (r_state == ST_WRITE) & r_bit;
    assign GRANT    = r_grant;
    assign BUSY     = (r_state != ST_ARB);

endmodule

// File: tb/tb_frame_source_arbiter.sv
// Randomized and directed bench for frame_source_arbiter against a timing-rule reference model.
module tb_frame_source_arbiter;

    localparam int PL          = 4;
    localparam int PH_IDLE     = 0;
    localparam int PH_WAIT     = 1;
    localparam int PH_TO_WRITE = 2;
    localparam int PH_READ_NOW = 3;

    logic       CLK       = 1'b0;
    logic       RESET     = 1'b1;
    logic       CH0_DATA  = 1'b0;
    logic       CH1_DATA  = 1'b0;
    logic       CH0_EMPTY = 1'b1;
    logic       CH1_EMPTY = 1'b1;
    logic       OUT_FULL  = 1'b0;
    logic       CH0_RE;
    logic       CH1_RE;
    logic       OUT_DATA;
    logic       OUT_WE;
    logic [1:0] GRANT;
    logic       BUSY;

    frame_source_arbiter #(.PAYLOAD_LEN(PL)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CH0_DATA  (CH0_DATA),
        .CH1_DATA  (CH1_DATA),
        .CH0_RE    (CH0_RE),
        .CH1_RE    (CH1_RE),
        .CH0_EMPTY (CH0_EMPTY),
        .CH1_EMPTY (CH1_EMPTY),
        .OUT_DATA  (OUT_DATA),
        .OUT_WE    (OUT_WE),
        .OUT_FULL  (OUT_FULL),
        .GRANT     (GRANT),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    // Requester FIFO contents (environment) and the model's own copies.
    bit q0[$];
    bit q1[$];
    bit m0[$];
    bit m1[$];

    int  cyc      = 0;
    int  m_owner  = 0;
    int  m_last   = 2;
    int  m_bits   = 0;
    int  m_phase  = PH_IDLE;
    int  m_from   = 0;
    bit  m_cap    = 1'b0;
    bit  rst_prev = 1'b1;
    bit  full_prev = 1'b0;
    bit  e0_prev  = 1'b1;
    bit  e1_prev  = 1'b1;

    bit         wlog[$];
    int         we_cyc[$];
    logic [1:0] glog[$];
    int         g_cyc[$];
    logic [1:0] prev_grant = 2'b00;

    task automatic push(input int ch, input bit b);
        if (ch == 0) begin
            q0.push_back(b);
            m0.push_back(b);
            CH0_EMPTY = 1'b0;
        end else begin
            q1.push_back(b);
            m1.push_back(b);
            CH1_EMPTY = 1'b0;
        end
    endtask

    // One clock: predict this cycle's outputs from the rules, compare, then let the FIFOs react.
    task automatic step();
        bit         ere0 = 1'b0;
        bit         ere1 = 1'b0;
        bit         ewe  = 1'b0;
        bit         edat = 1'b0;
        bit         clr  = 1'b0;
        bit         own_empty;
        bit         sre0;
        bit         sre1;
        logic [1:0] eg;
        logic [6:0] obs;
        logic [6:0] expv;
        if (rst_prev) begin
            m_owner = 0;
            m_last  = 2;
            m_bits  = 0;
            m_phase = PH_IDLE;
            m_from  = cyc;
        end else begin
            case (m_phase)
                PH_IDLE: begin
                    if (cyc - 1 >= m_from && (!e0_prev || !e1_prev)) begin
                        if (!e0_prev && !e1_prev) m_owner = (m_last == 1) ? 2 : 1;
                        else                      m_owner = (!e0_prev) ? 1 : 2;
                        m_phase = PH_READ_NOW;
                    end
                end
                PH_WAIT: begin
                    own_empty = (m_owner == 1) ? e0_prev : e1_prev;
                    if (cyc - 1 >= m_from && !own_empty) m_phase = PH_READ_NOW;
                end
                PH_TO_WRITE: begin
                    if (cyc >= m_from && !full_prev) begin
                        ewe  = 1'b1;
                        edat = m_cap;
                        m_bits++;
                        if (m_bits == PL) begin
                            clr     = 1'b1;
                            m_last  = m_owner;
                            m_bits  = 0;
                            m_phase = PH_IDLE;
                        end else begin
                            m_phase = PH_WAIT;
                        end
                        m_from = cyc + 1;
                    end
                end
                default: ;
            endcase
            if (m_phase == PH_READ_NOW) begin
                if (m_owner == 1) begin
                    ere0 = 1'b1;
                    if (m0.size() > 0) m_cap = m0.pop_front();
                end else begin
                    ere1 = 1'b1;
                    if (m1.size() > 0) m_cap = m1.pop_front();
                end
                m_phase = PH_TO_WRITE;
                m_from  = cyc + 3;
            end
        end
        eg   = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
        expv = {ere0, ere1, ewe, edat, eg, (m_owner != 0)};
        if (clr) m_owner = 0;
        obs  = {CH0_RE, CH1_RE, OUT_WE, OUT_DATA, GRANT, BUSY};
        check_val($sformatf("outs@%0d re0,re1,we,data,grant,busy", cyc), 32'(obs), 32'(expv));
        if (OUT_WE === 1'b1) begin
            wlog.push_back(OUT_DATA);
            we_cyc.push_back(cyc);
        end
        if (GRANT != 2'b00 && prev_grant == 2'b00) begin
            glog.push_back(GRANT);
            g_cyc.push_back(cyc);
        end
        prev_grant = GRANT;
        rst_prev   = RESET;
        full_prev  = OUT_FULL;
        e0_prev    = CH0_EMPTY;
        e1_prev    = CH1_EMPTY;
        sre0       = CH0_RE;
        sre1       = CH1_RE;
        @(posedge CLK);
        #1;
        if (sre0 && q0.size() > 0) CH0_DATA = q0.pop_front();
        if (sre1 && q1.size() > 0) CH1_DATA = q1.pop_front();
        CH0_EMPTY = (q0.size() == 0);
        CH1_EMPTY = (q1.size() == 0);
        @(negedge CLK);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        q0.delete();
        q1.delete();
        m0.delete();
        m1.delete();
        CH0_DATA  = 1'b0;
        CH1_DATA  = 1'b0;
        CH0_EMPTY = 1'b1;
        CH1_EMPTY = 1'b1;
        OUT_FULL  = 1'b0;
        wlog.delete();
        we_cyc.delete();
        glog.delete();
        g_cyc.delete();
    endtask

    task automatic check_log(input string tag, input bit exp_q[$]);
        check_val({tag, "_len"}, 32'(wlog.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
            check_val($sformatf("%s_bit%0d", tag, i), 32'(wlog[i]), 32'(exp_q[i]));
    endtask

    initial begin
        bit exp_q[$];
        int fall_cyc;
        int n_before;

        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        check_val("reset_outs", 32'({CH0_RE, CH1_RE, OUT_WE, OUT_DATA, GRANT, BUSY}), 32'd0);

        // Idle: both requesters empty.
        run(20);
        check_val("idle_we_count", 32'(wlog.size()), 32'd0);
        check_val("idle_grants", 32'(glog.size()), 32'd0);

        // Single requester, LSB-first block 1011.
        push(0, 1'b1); push(0, 1'b1); push(0, 1'b0); push(0, 1'b1);
        run(30);
        exp_q = '{1'b1, 1'b1, 1'b0, 1'b1};
        check_log("single", exp_q);
        if (g_cyc.size() > 0 && we_cyc.size() > 0)
            check_val("first_we_latency", 32'(we_cyc[0] - (g_cyc[0] - 1)), 32'd4);
        else
            check_val("first_we_seen", 32'(we_cyc.size()), 32'd1);
        for (int i = 1; i < we_cyc.size(); i++)
            check_val($sformatf("we_spacing%0d", i), 32'(we_cyc[i] - we_cyc[i-1]), 32'd5);

        // Contention: blocks alternate starting with CH0.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push(0, 1'b1);
            push(1, 1'b0);
        end
        run(100);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back((i / PL) % 2 == 0);
        check_log("alternate", exp_q);
        check_val("alt_grant_count", 32'(glog.size()), 32'd4);
        for (int i = 0; i < glog.size() && i < 4; i++)
            check_val($sformatf("alt_grant%0d", i), 32'(glog[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

        // Owner runs dry mid-block while the other channel waits.
        do_reset();
        push(0, 1'b1); push(0, 1'b0);
        push(1, 1'b0); push(1, 1'b1); push(1, 1'b1); push(1, 1'b0);
        run(25);
        check_val("stall_grant_held", 32'(GRANT), 32'd1);
        check_val("stall_bits", 32'(wlog.size()), 32'd2);
        push(0, 1'b1); push(0, 1'b1);
        run(60);
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        check_log("stall", exp_q);
        check_val("stall_grant_count", 32'(glog.size()), 32'd2);

        // Downstream full held for 10 cycles at CHECK_OUT.
        do_reset();
        push(0, 1'b1); push(0, 1'b0); push(0, 1'b1); push(0, 1'b0);
        for (int k = 0; k < 20 && CH0_RE !== 1'b1; k++) step();
        check_val("full_re_seen", 32'(CH0_RE), 32'd1);
        run(2);
        OUT_FULL = 1'b1;
        n_before = wlog.size();
        run(10);
        check_val("full_no_we", 32'(wlog.size()), 32'(n_before));
        OUT_FULL = 1'b0;
        fall_cyc = cyc;
        run(2);
        check_val("full_release_we", 32'(wlog.size()), 32'(n_before + 1));
        if (we_cyc.size() > 0) begin
            check_val("full_release_cycle", 32'(we_cyc[we_cyc.size()-1] - fall_cyc), 32'd1);
            check_val("full_release_bit", 32'(wlog[wlog.size()-1]), 32'd1);
        end
        run(40);
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b0};
        check_log("full", exp_q);

        // Reset mid-block restores CH0 priority on the next tie.
        do_reset();
        for (int i = 0; i < PL; i++) push(0, 1'b1);
        run(25);
        for (int i = 0; i < PL; i++) push(1, 1'b0);
        for (int k = 0; k < 40 && wlog.size() < 6; k++) step();
        check_val("midblk_bits", 32'(wlog.size()), 32'd6);
        do_reset();
        check_val("midblk_reset_outs", 32'({CH0_RE, CH1_RE, OUT_WE, OUT_DATA, GRANT, BUSY}), 32'd0);
        for (int i = 0; i < PL; i++) begin
            push(0, 1'b1);
            push(1, 1'b0);
        end
        run(10);
        check_val("midblk_grant_count", 32'(glog.size()), 32'd1);
        if (glog.size() > 0) check_val("midblk_first_owner", 32'(glog[0]), 32'd1);

        // Randomized traffic and back-pressure.
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 3) == 0) push(0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) push(1, 1'($urandom_range(0, 1)));
            OUT_FULL = ($urandom_range(0, 9) < 3);
            step();
        end
        OUT_FULL = 1'b0;
        run(100);
        check_val("rand_activity", 32'(wlog.size() > 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_source_arbiter.md
FRAME_SOURCE_ARBITER -- requirements
Module: frame_source_arbiter

Interface
REQ-001 SHALL have parameter: PAYLOAD_LEN, 48, number of bits per granted block (equals the frame-former payload length).
REQ-002 SHALL have port: CLK  input  1  clock; all logic on its rising edge.
REQ-003 SHALL have port: RESET  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: CH0_DATA  input  1  and CH1_DATA  input  1, requester FIFO read data, valid the cycle after the matching read enable.
REQ-005 SHALL have ports: CH0_RE  output  1  and CH1_RE  output  1, requester FIFO read enables.
REQ-006 SHALL have ports: CH0_EMPTY  input  1  and CH1_EMPTY  input  1, requester FIFO empty flags.
REQ-007 SHALL have port: OUT_DATA  output  1  bit written to the shared downstream FIFO.
REQ-008 SHALL have port: OUT_WE  output  1  downstream FIFO write enable.
REQ-009 SHALL have port: OUT_FULL  input  1  downstream FIFO full flag.
REQ-010 SHALL have port: GRANT  output  2  one-hot current owner; bit0 = CH0, bit1 = CH1; 2'b00 when no owner.
REQ-011 SHALL have port: BUSY  output  1  high whenever a block transfer is in progress (state other than ARB).

Function
REQ-012 SHALL implement FSM states ARB, WAIT_IN, READ, GET, CHECK_OUT, WRITE; undefined encodings SHALL return to ARB.
REQ-013 ARB: CH0 only non-empty -> grant CH0; CH1 only -> grant CH1; both -> grant the channel not served last; neither -> stay in ARB. On grant, go to READ.
REQ-014 WAIT_IN: stay while the granted channel's EMPTY=1; else go to READ.
REQ-015 READ: assert only the granted channel's RE for exactly 1 cycle; go to GET.
REQ-016 GET: capture the granted channel's DATA into an internal bit register; go to CHECK_OUT.
REQ-017 CHECK_OUT: stay while OUT_FULL=1; else go to WRITE.
REQ-018 WRITE: OUT_WE=1 for exactly 1 cycle, OUT_DATA = captured bit; increment the bit counter.
REQ-019 WRITE with bit counter = PAYLOAD_LEN-1: clear counter, record the granted channel as last-served, clear grant, go to ARB; otherwise go to WAIT_IN.
REQ-020 The grant SHALL be held for a full PAYLOAD_LEN-bit block; the granted channel going empty mid-block SHALL stall in WAIT_IN, never switch owner.
REQ-021 The non-granted channel's RE SHALL never assert; both REs SHALL never be high together.
REQ-022 OUT_WE, CHx_RE, OUT_DATA, GRANT, BUSY SHALL be decoded from registered state/grant only (no combinational path from inputs); OUT_DATA = 0 when OUT_WE = 0.
REQ-023 Minimum latency: 4 cycles from ARB grant decision to first OUT_WE; 5 cycles per subsequent bit with no stalls.
REQ-024 Bit counter width SHALL be $clog2(PAYLOAD_LEN); it SHALL never exceed PAYLOAD_LEN-1.
REQ-025 OUT_FULL toggling during non-CHECK_OUT states SHALL have no effect; EMPTY flags SHALL be sampled only in ARB and WAIT_IN.

Reset
REQ-026 RESET SHALL force state ARB, bit counter 0, grant 2'b00, captured bit 0, last-served = CH1 (so CH0 wins the first tie).
REQ-027 During and in the cycle after RESET: CH0_RE=CH1_RE=OUT_WE=OUT_DATA=BUSY=0, GRANT=2'b00.
REQ-028 RESET mid-block SHALL abandon the block without completing it; no further RE/WE until the next grant.

Structure
REQ-029 FSM state encodings and the channel index constants SHALL live in the shared frame-sync package.
REQ-030 The tie-break/grant logic SHALL be one sub-module, rr_grant2 (inputs two requests and last-served, outputs one-hot grant).

Verification (PAYLOAD_LEN = 4 on bench)
REQ-031 Both empty for 20 cycles -> no RE, no WE, GRANT=00, BUSY=0.
REQ-032 CH0 holds 1011, CH1 empty, OUT_FULL=0 -> OUT_WE pulses write 1,1,0,1 (LSB-first read order), first WE 4 cycles after grant, 5-cycle spacing, then ARB.
REQ-033 Both hold 8 bits (CH0 all 1, CH1 all 0) -> output 1111 0000 1111 0000; GRANT sequence 01,10,01,10.
REQ-034 CH0 grant, CH0 goes empty after 2 bits while CH1 non-empty -> arbiter waits in WAIT_IN, GRANT stays 01, CH1_RE never asserts until CH0 completes 4 bits.
REQ-035 OUT_FULL held high 10 cycles at CHECK_OUT -> no WE during stall; data bit written unchanged on the first cycle after OUT_FULL falls.
REQ-036 RESET asserted for 1 cycle after 2 bits of a block -> outputs zero next cycle; with both channels non-empty afterwards, CH0 granted first.
